fd_queue: RTL and testbench
===========================

# fd_queue

Parametrised fetch/decode decoupling queue for the combined ARM/RISC-V pipeline; it is the next generation of the single-entry fetch→decode pipeline register. Holds up to DEPTH fetched instructions with their PC, PC+4 and ISA-mode tag in a circular buffer. Fetch keeps issuing while decode is stalled, and the queue supplies decode without a refetch. Sits between stage_f and the decoder/regfile logic in stage_d, replacing the flopenr-based FD register.

## Interface
- XLEN, 32, instruction/PC width
- DEPTH, 4, entry count; power of two, ≥2
- TAGW, 1, per-entry mode tag width (bit 0 = arm)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- validF  in  1  fetch presents an instruction
- RDF  in  XLEN  fetched instruction word
- PCF, PCPlus4F  in  XLEN  fetch PC and PC+4
- tagF  in  TAGW  ISA mode of fetched instruction
- readyF  out  1  queue accepts a push this cycle
- validD  out  1  head entry valid for decode
- instrD  out  XLEN  head instruction
- PCD, PCPlus4D  out  XLEN  head PC and PC+4
- tagD  out  TAGW  head mode tag
- StallD  in  1  decode does not consume the head this cycle
- FlushD  in  1  discard all entries
- countD  out  $clog2(DEPTH)+1  occupancy

## Operation
- Push = validF & readyF; pop = validD & ~StallD.
- readyF = (count < DEPTH). It depends on registered count only and has no path from StallD. When full, a push is refused even if a pop occurs in the same cycle.
- Push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update: push only → +1; pop only → −1; both → unchanged.
- validD = (count != 0), except in bypass mode (see Configuration).
- instrD, PCD, PCPlus4D and tagD are zero whenever validD=0. This keeps bubbles deterministic and matches the current flushed-register behaviour.
- FlushD: next cycle count=0 and wr_ptr=rd_ptr=0. A push in the same cycle is dropped (flush wins over push). A pop in the same cycle is irrelevant.
- rst has identical effect to FlushD. Memory contents are not reset.
- Reset values: readyF=1, validD=0, countD=0, all data outputs 0.

## Timing
- Non-bypass latency: a push at edge N makes the entry visible at validD in cycle N+1.
- Throughput: 1 push and 1 pop per cycle, sustained at any occupancy between 1 and DEPTH-1.
- Head outputs are combinational reads of mem[rd_ptr], with no extra register.
- Empty with simultaneous push: validD stays 0 this cycle (non-bypass).
- Full with StallD=1: readyF=0, and head outputs hold stable indefinitely.
- Reset or flush asserted mid-burst: the queue is empty on the next cycle. readyF=1 on that cycle.

## Configuration
- FDQ_BYPASS_EN defined:
  - When count=0 and validF=1, validD=1 in the same cycle and head outputs show RDF/PCF/PCPlus4F/tagF.
  - If that entry is popped (StallD=0), it is not written and count stays 0.
  - If StallD=1, it is pushed normally.
  - FlushD=1 forces validD=0 in that cycle.
- FDQ_BYPASS_EN undefined: the one-cycle latency above applies unconditionally, and there is no combinational path from fetch inputs to decode outputs.

## Structure
- Shared package fdq_pkg:
  - typedef fd_entry_t: packed struct {instr, pc, pcplus4, tag}, widths from XLEN/TAGW.
  - localparam PTRW = $clog2(DEPTH).
  - function zero_entry.
- One sub-module, fdq_mem: DEPTH×$bits(fd_entry_t) flop array with one write port (we, waddr, wdata) and one asynchronous read port.
- fd_queue holds the pointers, the count, the bypass mux and the output masking.

## Test plan
- Reset: hold rst 2 cycles with validF=1 → validD=0, countD=0, readyF=1, instrD=0. No push is recorded.
- Fill and drain (DEPTH=4, StallD=1): push instr 0x00000013, 0x00100093, 0x00200113, 0x00300193 → countD=4 and readyF=0, and the 5th push is refused. Release StallD → the four instructions emerge in order with matching PCs over 4 cycles.
- Wrap-around: push/pop continuously for 10 cycles at occupancy 2 → output sequence equals input sequence, including across pointer wrap 3→0.
- Full with simultaneous pop: count=4, StallD=0, validF=1 → push refused, and count=3 next cycle.
- Flush with push: count=2, FlushD=1, validF=1 → next cycle countD=0 and validD=0. The pushed word never appears.
- Bypass: with FDQ_BYPASS_EN and queue empty, push PCF=0x100, tagF=1 with StallD=0 → same-cycle validD=1, PCD=0x100, tagD=1, and countD stays 0. Without the macro, the same stimulus gives validD=1 one cycle later.

Source files
------------

// File: rtl/fdq_pkg.sv
// Shared types for the fetch/decode queue: the per-entry record and default widths.
package fdq_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned TAGW_DEF  = 1;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned PTRW      = $clog2(DEPTH_DEF);

  typedef struct packed {
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] pcplus4;
    logic [TAGW_DEF-1:0] tag;
  } fd_entry_t;

  function automatic fd_entry_t zero_entry();
    zero_entry = '0;
  endfunction

endpackage

// File: rtl/fdq_mem.sv
// Entry storage for fd_queue: flop array, one synchronous write port, one asynchronous read port.
module fdq_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fd_queue.sv
// Fetch/decode decoupling queue (circular buffer of DEPTH entries).
// Optional same-cycle empty-queue bypass enabled by defining FDQ_BYPASS_EN.
module fd_queue
  import fdq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     validF,
  input  logic [XLEN-1:0]          RDF,
  input  logic [XLEN-1:0]          PCF,
  input  logic [XLEN-1:0]          PCPlus4F,
  input  logic [TAGW-1:0]          tagF,
  output logic                     readyF,
  output logic                     validD,
  output logic [XLEN-1:0]          instrD,
  output logic [XLEN-1:0]          PCD,
  output logic [XLEN-1:0]          PCPlus4D,
  output logic [TAGW-1:0]          tagD,
  input  logic                     StallD,
  input  logic                     FlushD,
  output logic [$clog2(DEPTH):0]   countD
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // The entry record lives in the shared package, so its widths must match.
  if (XLEN != XLEN_DEF || TAGW != TAGW_DEF) begin : g_width_chk
    $error("fd_queue: XLEN/TAGW must match fdq_pkg entry widths");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  fd_entry_t fetch_e, mem_e, head_e;
  logic      empty, push, pop, valid, wr_en, adv_rd;

  assign fetch_e = '{instr: RDF, pc: PCF, pcplus4: PCPlus4F, tag: tagF};

  assign empty  = (count_q == '0);
  assign readyF = (count_q < CW'(DEPTH));
  assign push   = validF & readyF;
  assign pop    = valid & ~StallD;

`ifdef FDQ_BYPASS_EN
  logic byp;
  // An empty queue forwards fetch straight to decode; the entry is only
  // stored if decode stalls on it, and the read pointer never moves for it.
  assign byp    = empty & validF;
  assign valid  = (~empty | validF) & ~FlushD & ~rst;
  assign wr_en  = push & ~(byp & ~StallD);
  assign adv_rd = pop & ~empty;
  assign head_e = byp ? fetch_e : mem_e;
`else
  assign valid  = ~empty;
  assign wr_en  = push;
  assign adv_rd = pop;
  assign head_e = mem_e;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (adv_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, adv_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fdq_mem #(
    .DEPTH (DEPTH),
    .W     ($bits(fd_entry_t))
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en & ~FlushD & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (fetch_e),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_e)
  );

  fd_entry_t out_e;
  assign out_e    = valid ? head_e : zero_entry();
  assign validD   = valid;
  assign instrD   = out_e.instr;
  assign PCD      = out_e.pc;
  assign PCPlus4D = out_e.pcplus4;
  assign tagD     = out_e.tag;
  assign countD   = count_q;

endmodule

// File: tb/tb_fd_queue.sv
// Directed self-checking bench for fd_queue (DEPTH=4); follows FDQ_BYPASS_EN if defined.
module tb_fd_queue;

`ifdef FDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, validF, StallD, FlushD;
  logic [31:0] RDF, PCF, PCPlus4F;
  logic [0:0]  tagF;
  logic        readyF, validD;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic [0:0]  tagD;
  logic [2:0]  countD;

  int n_chk  = 0;
  int n_fail = 0;

  fd_queue #(.XLEN(32), .DEPTH(4), .TAGW(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .validF   (validF),
    .RDF      (RDF),
    .PCF      (PCF),
    .PCPlus4F (PCPlus4F),
    .tagF     (tagF),
    .readyF   (readyF),
    .validD   (validD),
    .instrD   (instrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .tagD     (tagD),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .countD   (countD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic t);
    validF   = v;
    RDF      = ins;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
    tagF     = t;
  endtask

  logic [31:0] instrs [4];
  logic [31:0] q [$];
  logic [31:0] nv;
  int          k;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    instrs[0] = 32'h0000_0013;
    instrs[1] = 32'h0010_0093;
    instrs[2] = 32'h0020_0113;
    instrs[3] = 32'h0030_0193;
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0FF0, 1'b1);
    #1;
    tick(); tick();

    // reset
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    check("rst_validD", validD, 0);
    check("rst_countD", countD, 0);
    check("rst_readyF", readyF, 1);
    check("rst_instrD", instrD, 0);

    // fill with decode stalled
    StallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, instrs[i], 32'h1000 + 32'(4 * i), i[0]);
      tick();
    end
    validF = 1'b0;
    #1;
    check("full_countD", countD, 4);
    check("full_readyF", readyF, 0);
    check("full_head", instrD, 32'h0000_0013);
    drive(1'b1, 32'hDEAD_BEEF, 32'h1010, 1'b0);
    #1;
    check("full_ready_push", readyF, 0);
    tick();
    validF = 1'b0;
    #1;
    check("refused_countD", countD, 4);
    check("refused_head", instrD, 32'h0000_0013);

    // drain in order
    StallD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_validD", validD, 1);
      check("drain_instrD", instrD, instrs[i]);
      check("drain_PCD", PCD, 32'h1000 + 32'(4 * i));
      check("drain_PCPlus4D", PCPlus4D, 32'h1004 + 32'(4 * i));
      check("drain_tagD", tagD, i[0]);
      tick();
    end
    check("drained_validD", validD, 0);
    check("drained_countD", countD, 0);
    check("drained_instrD", instrD, 0);

    // wrap-around at occupancy 2
    StallD = 1'b1;
    k = 0;
    for (int i = 0; i < 2; i++) begin
      nv = 32'hA000_0000 + 32'(k);
      drive(1'b1, nv, 32'h2000 + 32'(4 * k), 1'b0);
      q.push_back(nv);
      k++;
      tick();
    end
    StallD = 1'b0;
    for (int c = 0; c < 10; c++) begin
      nv = 32'hA000_0000 + 32'(k);
      drive(1'b1, nv, 32'h2000 + 32'(4 * k), 1'b0);
      #1;
      check("wrap_instrD", instrD, q[0]);
      check("wrap_countD", countD, 2);
      void'(q.pop_front());
      q.push_back(nv);
      k++;
      tick();
    end

    // fill to 4, then pop while full with fetch offering
    StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nv = 32'hA000_0000 + 32'(k);
      drive(1'b1, nv, 32'h2000 + 32'(4 * k), 1'b0);
      q.push_back(nv);
      k++;
      tick();
    end
    StallD = 1'b0;
    drive(1'b1, 32'hBBBB_BBBB, 32'h2F00, 1'b0);
    #1;
    check("fullpop_readyF", readyF, 0);
    check("fullpop_head", instrD, q[0]);
    tick();
    void'(q.pop_front());
    validF = 1'b0;
    #1;
    check("fullpop_countD", countD, 3);
    check("fullpop_next", instrD, q[0]);

    // flush with push at occupancy 2
    tick();
    void'(q.pop_front());
    check("preflush_countD", countD, 2);
    FlushD = 1'b1;
    drive(1'b1, 32'hBADB_AD00, 32'h3000, 1'b1);
    tick();
    FlushD = 1'b0;
    validF = 1'b0;
    #1;
    check("flush_countD", countD, 0);
    check("flush_validD", validD, 0);
    check("flush_readyF", readyF, 1);
    check("flush_instrD", instrD, 0);
    tick();
    check("flush_noghost", validD, 0);

    // empty-queue push with decode ready
    StallD = 1'b0;
    drive(1'b1, 32'h0000_0513, 32'h0000_0100, 1'b1);
    #1;
    check("byp_same_validD", validD, BYP);
    check("byp_same_PCD", PCD, BYP ? 32'h100 : 32'h0);
    check("byp_same_tagD", tagD, BYP);
    tick();
    validF = 1'b0;
    #1;
`ifdef FDQ_BYPASS_EN
    check("byp_next_validD", validD, 0);
    check("byp_next_countD", countD, 0);
`else
    check("byp_next_validD", validD, 1);
    check("byp_next_PCD", PCD, 32'h100);
    check("byp_next_tagD", tagD, 1);
    check("byp_next_countD", countD, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
